// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one load or store per start over a req/ack data port.
// Optional define LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic             busy_d, done_d, error_d, mem_req_d, mem_we_d;
  logic [31:0]      rdata_d, mem_addr_d, mem_wdata_d;
  logic [3:0]       mem_be_d;

  logic        req_ok_c, misalign_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_rep_c, load_ext_c, shifted_c;

  // Request decode: funct3 legality, optional alignment trap, lanes and enables
  always_comb begin
    if (we) req_ok_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else    req_ok_c = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
    case (funct3[1:0])
      2'b00:   begin be_c = 4'b0001 << addr[1:0];         wdata_rep_c = {4{wdata[7:0]}};  end
      2'b01:   begin be_c = 4'b0011 << {addr[1], 1'b0};   wdata_rep_c = {2{wdata[15:0]}}; end
      default: begin be_c = 4'b1111;                       wdata_rep_c = wdata;            end
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched request
  always_comb begin
    if (f3_q[0]) shifted_c = mem_rdata >> {lane_q[1], 4'b0000};
    else         shifted_c = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_ext_c = {24'h000000, shifted_c[7:0]};
      3'b001:  load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_ext_c = {16'h0000, shifted_c[15:0]};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    rdata_d     = rdata;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    case (state_q)
      IDLE: begin
        if (start) begin
          we_d   = we;
          f3_d   = funct3;
          lane_d = addr[1:0];
          if (req_ok_c && !misalign_c) begin
            state_d     = REQ;
            cnt_d       = '0;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = we;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = wdata_rep_c;
            mem_be_d    = be_c;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = load_ext_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      rdata     <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand sequences for
// busy/DONE start filtering, back-to-back start and reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, error;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int nchecks = 0;
  int nerrors = 0;
  logic [31:0] model_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;    // memory word returned on ack
    int          dly;    // REQ cycles before ack, -1 = never ack
    logic        req;    // memory request expected
    logic [3:0]  be;
    logic [31:0] mwd;    // expected mem_wdata (stores)
    logic        keep;   // rdata expected unchanged
    logic [31:0] rd;
    logic        err;
    int          lat;    // start to done, cycles
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int  lat, reqc;
    bit  got;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; reqc = 0; got = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k; got = 1; break; end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (reqc == 0) begin
          check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
          check($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.be));
          check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
          if (v.we) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwd);
        end
        if (v.dly >= 0 && reqc == v.dly) begin
          mem_ack = 1'b1;
          mem_rdata = v.mrd;
        end
        reqc++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
    end
    check($sformatf("v%0d done seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d error", idx), 32'(error), 32'(v.err));
    check($sformatf("v%0d req cycles", idx), 32'(reqc),
          !v.req ? 32'd0 : (v.dly < 0 ? 32'd16 : 32'(v.dly + 1)));
    check($sformatf("v%0d req low at done", idx), 32'(mem_req), 32'd0);
    check($sformatf("v%0d busy low at done", idx), 32'(busy), 32'd0);
    exp_rd = v.keep ? model_rdata : v.rd;
    model_rdata = exp_rd;
    check($sformatf("v%0d rdata", idx), rdata, exp_rd);
    @(posedge clk); #1;
    check($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //          we  f3      addr          wdata         mrd           dly req be     mwd           keep rd            err lat
    vecs[0]  = '{1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 0,  1'b1, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 2};
    vecs[1]  = '{1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF0000, 0,  1'b1, 4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 2};
    vecs[2]  = '{1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FF0000, 1,  1'b1, 4'h8, 32'h0,        1'b0, 32'h00000080, 1'b0, 3};
    vecs[3]  = '{1'b1, 3'b001, 32'h00000022, 32'h1234ABCD, 32'h0,        0,  1'b1, 4'hC, 32'hABCDABCD, 1'b1, 32'h0,        1'b0, 2};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4]  = '{1'b0, 3'b010, 32'h00000102, 32'h0,        32'h11223344, 0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1, 1};
    vecs[5]  = '{1'b0, 3'b001, 32'h00000101, 32'h0,        32'hAAAA7FFF, 0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1, 1};
`else
    vecs[4]  = '{1'b0, 3'b010, 32'h00000102, 32'h0,        32'h11223344, 0,  1'b1, 4'hF, 32'h0,        1'b0, 32'h11223344, 1'b0, 2};
    vecs[5]  = '{1'b0, 3'b001, 32'h00000101, 32'h0,        32'hAAAA7FFF, 0,  1'b1, 4'h3, 32'h0,        1'b0, 32'h00007FFF, 1'b0, 2};
`endif
    vecs[6]  = '{1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80011234, 3,  1'b1, 4'hC, 32'h0,        1'b0, 32'hFFFF8001, 1'b0, 5};
    vecs[7]  = '{1'b0, 3'b101, 32'h00000100, 32'h0,        32'h8001F234, 0,  1'b1, 4'h3, 32'h0,        1'b0, 32'h0000F234, 1'b0, 2};
    vecs[8]  = '{1'b1, 3'b000, 32'h00000101, 32'h1234565A, 32'h0,        2,  1'b1, 4'h2, 32'h5A5A5A5A, 1'b1, 32'h0,        1'b0, 4};
    vecs[9]  = '{1'b1, 3'b010, 32'h00000200, 32'hCAFEBABE, 32'h0,        0,  1'b1, 4'hF, 32'hCAFEBABE, 1'b1, 32'h0,        1'b0, 2};
    vecs[10] = '{1'b0, 3'b011, 32'h00000300, 32'h0,        32'h0,        0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1, 1};
    vecs[11] = '{1'b1, 3'b100, 32'h00000300, 32'h55555555, 32'h0,        0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1, 1};
    vecs[12] = '{1'b0, 3'b000, 32'h00000401, 32'h0,        32'h00007F00, 0,  1'b1, 4'h2, 32'h0,        1'b0, 32'h0000007F, 1'b0, 2};
    vecs[13] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        -1, 1'b1, 4'hF, 32'h0,        1'b1, 32'h0,        1'b1, 17};
    vecs[14] = '{1'b1, 3'b110, 32'h00000000, 32'h0,        32'h0,        0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run(vecs[i], i);

    // start while busy and while in DONE is dropped; next start after done is taken
    @(posedge clk); #1;
    we = 1'b0; funct3 = 3'b010; addr = 32'h00000500; start = 1'b1;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h00000600; funct3 = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy start addr", mem_addr, 32'h00000500);
    check("busy start we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("busy seq done", 32'(done), 32'd1);
    check("busy seq rdata", rdata, 32'h13579BDF);
    model_rdata = 32'h13579BDF;
    start = 1'b1; we = 1'b0; funct3 = 3'b011;
    @(posedge clk); #1;
    start = 1'b0;
    check("start in done ignored", 32'(done), 32'd0);
    check("start in done no req", 32'(mem_req), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done", 32'(done), 32'd1);
    check("b2b error", 32'(error), 32'd1);
    check("b2b rdata kept", rdata, model_rdata);

    // reset during REQ: outputs drop at once and no done follows
    @(posedge clk); #1;
    we = 1'b0; funct3 = 3'b010; addr = 32'h00000700; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre-reset req", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst mem_req", 32'(mem_req), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
        if (done || mem_req) pulses++;
        @(posedge clk); #1;
      end
      check("no done after abort", 32'(pulses), 32'd0);
    end
    check("rdata cleared by reset", rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
